// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: operand bypass, load-use stall, control flush, multdiv sequencing.
// Optional perf counters (stall/flush cycles) are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_MAX_CYC = 40,
  parameter int PERF_W     = 16
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rs_d,
  input  logic             uses_rt_d,
  input  logic [REG_W-1:0] rs_x,
  input  logic [REG_W-1:0] rt_x,
  input  logic [REG_W-1:0] rd_x,
  input  logic             regwrite_x,
  input  logic             memread_x,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             branch_taken_x,
  input  logic             jump_x,
  input  logic             md_start_x,
  input  logic             md_ready,
  output logic [1:0]       bypass_a,
  output logic [1:0]       bypass_b,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             md_go,
  output logic             md_busy,
  output logic             md_error
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  localparam int CNT_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYC - 1);

  if (REG_W < 1 || PERF_W < 1 || MD_MAX_CYC < 2) begin : g_param_check
    $error("pipeline_hazard_ctrl: invalid parameter values");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] md_cnt, md_cnt_next;
  logic             md_error_q;
  logic             md_timeout;
  logic             fl, lu, in_run;

  // M stage is younger than W, so its result wins; $r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic wr_m, input logic [REG_W-1:0] dst_m,
                                         input logic wr_w, input logic [REG_W-1:0] dst_w);
    if (wr_m && dst_m == src && dst_m != '0)      return 2'b01;
    else if (wr_w && dst_w == src && dst_w != '0) return 2'b10;
    else                                          return 2'b00;
  endfunction

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state      <= IDLE;
      md_cnt     <= '0;
      md_error_q <= 1'b0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      if (md_timeout) md_error_q <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    md_timeout  = 1'b0;
    fl          = branch_taken_x | jump_x;
    lu          = memread_x & regwrite_x & (rd_x != '0) &
                  ((uses_rs_d & (rs_d == rd_x)) | (uses_rt_d & (rt_d == rd_x)));
    in_run      = (state == MD_RUN);

    case (state)
      IDLE: begin
        if (md_start_x && !fl) begin
          state_next  = MD_RUN;
          md_cnt_next = '0;
        end
      end
      MD_RUN: begin
        md_cnt_next = md_cnt + 1'b1;
        // A ready pulse on the last allowed cycle still counts as success.
        if (md_ready) begin
          state_next = MD_DONE;
        end else if (md_cnt == CNT_LAST) begin
          state_next = IDLE;
          md_timeout = 1'b1;
        end
      end
      MD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bypass_a  = 2'b00;
    bypass_b  = 2'b00;
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    md_go     = 1'b0;
    md_busy   = 1'b0;
    md_error  = 1'b0;
    if (ctrl_reset) begin
      bypass_a  = fwd_sel(rs_x, regwrite_m, rd_m, regwrite_w, rd_w);
      bypass_b  = fwd_sel(rt_x, regwrite_m, rd_m, regwrite_w, rd_w);
      // Multdiv freeze dominates; a load-use stall is dropped when X is being flushed.
      stall_pc  = in_run | (lu & ~fl);
      stall_fd  = in_run | (lu & ~fl);
      stall_dx  = in_run;
      bubble_dx = lu & ~fl & ~in_run;
      bubble_xm = in_run;
      flush_fd  = fl;
      flush_dx  = fl;
      md_go     = (state == IDLE) & md_start_x & ~fl;
      md_busy   = (state != IDLE);
      md_error  = md_error_q;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_pc && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
      if (flush_fd && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign perf_stall_cnt = ctrl_reset ? perf_stall_q : '0;
  assign perf_flush_cnt = ctrl_reset ? perf_flush_q : '0;
`endif

endmodule
